// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared definitions for the UART receive path
//
// Purpose: receiver state encoding, receive FIFO entry layout and the
// default bit period. Optional feature macro: UART_RX_PARITY_EN (adds the
// PARITY state and a parity-error bit to each FIFO entry).
// Ports: none (package).

package uart_pkg;

   // 115200 baud from a 100 MHz clock.
   localparam int UART_CLK_DIVIDE_DEFAULT = 868;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY    = 3'd3,
`endif
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } uart_rx_state_t;

   // FIFO entry layout, LSB upward: {parityErr, frameErr, data}.
   localparam int UART_DATA_OFS = 0;

   function automatic int uart_ferr_ofs(input int data_bits);
      return data_bits;
   endfunction

   function automatic int uart_perr_ofs(input int data_bits);
      return data_bits + 1;
   endfunction

   function automatic int uart_entry_width(input int data_bits);
`ifdef UART_RX_PARITY_EN
      return data_bits + 2;
`else
      return data_bits + 1;
`endif
   endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// rtl/uart_rx_fifo_mem.sv - synchronous FIFO with push/pop/full/empty/count
//
// Purpose: small register-based FIFO, head shown combinationally from the
// read pointer. A push while full is accepted only if a pop happens in the
// same cycle; otherwise it is ignored (the caller flags the loss).
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_push, i_push_data  write request and word
//   i_pop              remove head (ignored when empty)
//   o_head             head word, 0 while empty
//   o_full, o_empty    occupancy flags
//   o_count            occupancy, 0..DEPTH

module uart_rx_fifo_mem #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WIDTH < 1) begin : g_bad_params
      $error("uart_rx_fifo_mem: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign o_empty = (count == '0);
   assign o_full  = (count == (AW+1)'(DEPTH));
   assign o_count = count;
   assign o_head  = o_empty ? '0 : mem[rd_ptr];

   assign do_pop  = i_pop && !o_empty;
   // When full, the slot being written is the one the pop frees.
   assign do_push = i_push && (!o_full || do_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= i_push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - parametrised UART receiver with receive FIFO
//
// Purpose: 2-flop synchronised, glitch-rejecting UART receiver with framing,
// optional parity, break and overrun detection, feeding a valid/ready FIFO.
// Optional feature macro: UART_RX_PARITY_EN (one parity bit after the data).
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_serialIn         asynchronous RX line, idle high
//   o_valid, i_ready   FIFO head handshake
//   o_data             head data, LSB = first received bit
//   o_frameErr         head word had a low stop bit
//   o_parityErr        head word failed parity (0 without the macro)
//   o_break, o_overrun sticky flags, cleared by i_clearErr
//   o_count            FIFO occupancy

module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_DIVIDE = UART_CLK_DIVIDE_DEFAULT,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_serialIn,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [DATA_BITS-1:0]          o_data,
   output logic                          o_frameErr,
   output logic                          o_parityErr,
   output logic                          o_break,
   output logic                          o_overrun,
   input  logic                          i_clearErr,
   output logic [$clog2(FIFO_DEPTH):0]   o_count
);

   localparam int CW       = $clog2(CLK_DIVIDE);
   localparam int BW       = $clog2(DATA_BITS);
   localparam int EW       = uart_entry_width(DATA_BITS);
   localparam int FERR_BIT = uart_ferr_ofs(DATA_BITS);
`ifdef UART_RX_PARITY_EN
   localparam int PERR_BIT = uart_perr_ofs(DATA_BITS);
`endif

   localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIVIDE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIVIDE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   if (CLK_DIVIDE < 4 || DATA_BITS < 5 || DATA_BITS > 8 ||
       (STOP_BITS != 1 && STOP_BITS != 2) ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_rx_fifo: illegal parameter combination");
   end

   // Pure synchroniser, deliberately not reset: a line held low across
   // reset stays low here, so WAIT_HIGH cannot be fooled into decoding the
   // tail of an interrupted frame.
   logic rx_meta;
   logic rx;

   always_ff @(posedge i_clk) begin
      rx_meta <= i_serialIn;
      rx      <= rx_meta;
   end

   uart_rx_state_t       state_q, state_n;
   logic [CW-1:0]        cnt_q, cnt_n;
   logic [BW-1:0]        bit_q, bit_n;
   logic [DATA_BITS-1:0] sr_q, sr_n;
   logic                 ferr_q, ferr_n;
   logic                 perr_q, perr_n;
   logic                 push_q, push_n;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_WAIT_HIGH;
         cnt_q   <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         push_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         bit_q   <= bit_n;
         sr_q    <= sr_n;
         ferr_q  <= ferr_n;
         perr_q  <= perr_n;
         push_q  <= push_n;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      bit_n   = bit_q;
      sr_n    = sr_q;
      ferr_n  = ferr_q;
      perr_n  = perr_q;
      push_n  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx) begin
               state_n = ST_START;
               cnt_n   = '0;
            end
         end
         ST_START: begin
            if (rx) begin
               state_n = ST_IDLE;
            end else if (cnt_q == CNT_HALF) begin
               state_n = ST_DATA;
               cnt_n   = '0;
               bit_n   = '0;
               ferr_n  = 1'b0;
               perr_n  = 1'b0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_n = '0;
               sr_n  = {rx, sr_q[DATA_BITS-1:1]};
               if (bit_q == DATA_LAST) begin
                  bit_n = '0;
`ifdef UART_RX_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
               end else begin
                  bit_n = bit_q + 1'b1;
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_n   = '0;
               perr_n  = rx ^ (^sr_q) ^ 1'(PARITY_ODD);
               state_n = ST_STOP;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_n = '0;
               if (!rx) begin
                  ferr_n = 1'b1;
               end
               if (bit_q == STOP_LAST) begin
                  bit_n   = '0;
                  push_n  = 1'b1;
                  // A low stop bit may be a break still in progress, so
                  // the line must go high before a new start is looked for.
                  state_n = (ferr_q || !rx) ? ST_WAIT_HIGH : ST_IDLE;
               end else begin
                  bit_n = bit_q + 1'b1;
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         ST_WAIT_HIGH: begin
            if (rx) begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_WAIT_HIGH;
      endcase
   end

   logic [EW-1:0] push_word;
   logic [EW-1:0] head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;

   always_comb begin
      push_word                               = '0;
      push_word[UART_DATA_OFS +: DATA_BITS]   = sr_q;
      push_word[FERR_BIT]                     = ferr_q;
`ifdef UART_RX_PARITY_EN
      push_word[PERR_BIT]                     = perr_q;
`endif
   end

   assign pop = o_valid && i_ready;

   uart_rx_fifo_mem #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_push      (push_q),
      .i_push_data (push_word),
      .i_pop       (pop),
      .o_head      (head),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_count     (o_count)
   );

   assign o_valid    = !fifo_empty;
   assign o_data     = head[UART_DATA_OFS +: DATA_BITS];
   assign o_frameErr = head[FERR_BIT];
`ifdef UART_RX_PARITY_EN
   assign o_parityErr = head[PERR_BIT];
`else
   assign o_parityErr = 1'b0;
`endif

   logic break_set;
   logic overrun_set;

   assign break_set   = push_q && ferr_q && (sr_q == '0);
   assign overrun_set = push_q && fifo_full && !pop;

   // Setting wins over a same-cycle clear so no event is lost.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_break   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         if (break_set) begin
            o_break <= 1'b1;
         end else if (i_clearErr) begin
            o_break <= 1'b0;
         end
         if (overrun_set) begin
            o_overrun <= 1'b1;
         end else if (i_clearErr) begin
            o_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
//
// Purpose: drives 8N1 (8E1 with UART_RX_PARITY_EN) frames at 16 clocks per
// bit and checks received words, error flags, FIFO occupancy and latency.
// Ports: none (top-level bench).

module tb_uart_rx_fifo;

   localparam int CLK_DIVIDE = 16;
`ifdef UART_RX_PARITY_EN
   localparam int P_BITS = 1;
`else
   localparam int P_BITS = 0;
`endif
   // pin edge -> t0 is 3 edges (2 sync + IDLE sample), then t0+8+(8+P+1)*16+1
   localparam int LATENCY = 3 + 8 + (8 + P_BITS + 1) * CLK_DIVIDE + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       serial = 1'b1;
   logic       ready = 1'b0;
   logic       clear_err = 1'b0;
   logic       valid;
   logic [7:0] data;
   logic       frame_err;
   logic       parity_err;
   logic       brk;
   logic       overrun;
   logic [2:0] count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t_start = 0;

   uart_rx_fifo #(
      .CLK_DIVIDE (CLK_DIVIDE),
      .DATA_BITS  (8),
      .STOP_BITS  (1),
      .PARITY_ODD (0),
      .FIFO_DEPTH (4)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_serialIn  (serial),
      .o_valid     (valid),
      .i_ready     (ready),
      .o_data      (data),
      .o_frameErr  (frame_err),
      .o_parityErr (parity_err),
      .o_break     (brk),
      .o_overrun   (overrun),
      .i_clearErr  (clear_err),
      .o_count     (count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Frame starts #1 after a posedge; each bit lasts CLK_DIVIDE clocks.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      @(posedge clk); #1;
      serial = 1'b0;
      t_start = cyc;
      for (int i = 0; i < 8; i++) begin
         repeat (CLK_DIVIDE) @(posedge clk); #1;
         serial = d[i];
      end
      if (P_BITS == 1) begin
         repeat (CLK_DIVIDE) @(posedge clk); #1;
         serial = par;
      end
      repeat (CLK_DIVIDE) @(posedge clk); #1;
      serial = stop;
      repeat (CLK_DIVIDE) @(posedge clk); #1;
      serial = 1'b1;
   endtask

   task automatic pop_word(output logic v, output logic [7:0] d, output logic fe, output logic pe);
      @(negedge clk);
      v = valid; d = data; fe = frame_err; pe = parity_err;
      if (v) begin
         ready = 1'b1;
         @(posedge clk); #1;
         ready = 1'b0;
      end
   endtask

   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

   task automatic test_reset;
      serial = 1'b1;
      reset = 1'b1;
      idle(5);
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (brk !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_sticky got %0b%0b want 00", brk, overrun); end
      checks++; if (data !== 8'h00 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
         errors++; $display("FAIL reset_head got %0h/%0b/%0b want 0/0/0", data, frame_err, parity_err); end
      #1 reset = 1'b0;
      idle(10);
   endtask

   task automatic test_basic;
      logic got;
      int   t_seen;
      logic [7:0] d;
      logic fe, pe;
      got = 1'b0; t_seen = 0; d = '0; fe = 1'b0; pe = 1'b0;
      ready = 1'b1;
      fork
         send_frame(8'hA5, even_par(8'hA5), 1'b1);
         begin : mon
            for (int n = 0; n < 400 && !got; n++) begin
               @(negedge clk);
               if (valid) begin
                  got = 1'b1; t_seen = cyc; d = data; fe = frame_err; pe = parity_err;
               end
            end
         end
      join
      ready = 1'b0;
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL basic_timeout got no beat want one beat"); end
      checks++; if (t_seen - t_start != LATENCY) begin errors++; $display("FAIL basic_latency got %0d want %0d", t_seen - t_start, LATENCY); end
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL basic_data got %0h want a5", d); end
      checks++; if (fe !== 1'b0 || pe !== 1'b0) begin errors++; $display("FAIL basic_flags got %0b%0b want 00", fe, pe); end
      idle(5);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count got %0d want 0", count); end
   endtask

   task automatic test_glitch_and_reset;
      logic v; logic [7:0] d; logic fe, pe;
      @(posedge clk); #1 serial = 1'b0;
      idle(4);
      serial = 1'b1;
      idle(200);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", count); end
      send_frame(8'h11, even_par(8'h11), 1'b1);
      idle(20);
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL prereset_count got %0d want 1", count); end
      fork
         send_frame(8'hF0, even_par(8'hF0), 1'b1);
         begin
            idle(57);
            reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            @(negedge clk);
            checks++; if (count !== 3'd0 || valid !== 1'b0) begin
               errors++; $display("FAIL midreset_empty got count %0d valid %0b want 0 0", count, valid); end
         end
      join
      idle(40);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL inflight_ignored got count %0d want 0", count); end
      send_frame(8'h3C, even_par(8'h3C), 1'b1);
      idle(20);
      pop_word(v, d, fe, pe);
      checks++; if (v !== 1'b1 || d !== 8'h3C || fe !== 1'b0) begin
         errors++; $display("FAIL postreset_word got v%0b %0h fe%0b want v1 3c fe0", v, d, fe); end
   endtask

   task automatic test_frame_err;
      logic v; logic [7:0] d; logic fe, pe;
      send_frame(8'h3C, even_par(8'h3C), 1'b0);
      idle(20);
      send_frame(8'h55, even_par(8'h55), 1'b1);
      idle(20);
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL ferr_count got %0d want 2", count); end
      pop_word(v, d, fe, pe);
      checks++; if (v !== 1'b1 || d !== 8'h3C || fe !== 1'b1) begin
         errors++; $display("FAIL ferr_word got v%0b %0h fe%0b want v1 3c fe1", v, d, fe); end
      pop_word(v, d, fe, pe);
      checks++; if (v !== 1'b1 || d !== 8'h55 || fe !== 1'b0) begin
         errors++; $display("FAIL ferr_next got v%0b %0h fe%0b want v1 55 fe0", v, d, fe); end
      checks++; if (brk !== 1'b0) begin errors++; $display("FAIL ferr_nobreak got %0b want 0", brk); end
   endtask

   task automatic test_break;
      logic v; logic [7:0] d; logic fe, pe;
      @(posedge clk); #1 serial = 1'b0;
      idle(30 * CLK_DIVIDE);
      serial = 1'b1;
      idle(40);
      send_frame(8'h55, even_par(8'h55), 1'b1);
      idle(20);
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL break_count got %0d want 2", count); end
      checks++; if (brk !== 1'b1) begin errors++; $display("FAIL break_flag got %0b want 1", brk); end
      pop_word(v, d, fe, pe);
      checks++; if (v !== 1'b1 || d !== 8'h00 || fe !== 1'b1) begin
         errors++; $display("FAIL break_word got v%0b %0h fe%0b want v1 00 fe1", v, d, fe); end
      pop_word(v, d, fe, pe);
      checks++; if (v !== 1'b1 || d !== 8'h55 || fe !== 1'b0) begin
         errors++; $display("FAIL break_next got v%0b %0h fe%0b want v1 55 fe0", v, d, fe); end
      @(negedge clk) clear_err = 1'b1;
      @(posedge clk); #1 clear_err = 1'b0;
      @(negedge clk);
      checks++; if (brk !== 1'b0) begin errors++; $display("FAIL break_clear got %0b want 0", brk); end
   endtask

   task automatic test_overrun;
      logic v; logic [7:0] d; logic fe, pe;
      logic [7:0] w;
      for (int i = 1; i <= 4; i++) begin
         w = 8'(i);
         send_frame(w, even_par(w), 1'b1);
         idle(4);
      end
      checks++; if (count !== 3'd4 || overrun !== 1'b0) begin
         errors++; $display("FAIL full_state got count %0d ovr %0b want 4 0", count, overrun); end
      send_frame(8'h05, even_par(8'h05), 1'b1);
      idle(4);
      checks++; if (count !== 3'd4 || overrun !== 1'b1) begin
         errors++; $display("FAIL overrun_state got count %0d ovr %0b want 4 1", count, overrun); end
      for (int i = 1; i <= 4; i++) begin
         pop_word(v, d, fe, pe);
         checks++; if (v !== 1'b1 || d !== 8'(i)) begin
            errors++; $display("FAIL overrun_pop%0d got v%0b %0h want v1 %0h", i, v, d, i); end
      end
      @(negedge clk);
      checks++; if (count !== 3'd0 || valid !== 1'b0) begin
         errors++; $display("FAIL overrun_drain got count %0d valid %0b want 0 0", count, valid); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0b want 1", overrun); end
      clear_err = 1'b1;
      @(posedge clk); #1 clear_err = 1'b0;
      @(negedge clk);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %0b want 0", overrun); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      logic v; logic [7:0] d; logic fe, pe;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(10);
      send_frame(8'h07, 1'b0, 1'b1);
      idle(10);
      pop_word(v, d, fe, pe);
      checks++; if (v !== 1'b1 || d !== 8'h07 || pe !== 1'b0 || fe !== 1'b0) begin
         errors++; $display("FAIL parity_good got v%0b %0h pe%0b fe%0b want v1 07 pe0 fe0", v, d, pe, fe); end
      pop_word(v, d, fe, pe);
      checks++; if (v !== 1'b1 || d !== 8'h07 || pe !== 1'b1 || fe !== 1'b0) begin
         errors++; $display("FAIL parity_bad got v%0b %0h pe%0b fe%0b want v1 07 pe1 fe0", v, d, pe, fe); end
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_glitch_and_reset;
      test_frame_err;
      test_break;
      test_overrun;
`ifdef UART_RX_PARITY_EN
      test_parity;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
